// File: rtl/perm_step_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// perm_step_scheduler: SpoC-64 sLiSCP-light step/round sequencer.
// Optional SCHED_HOLD_EN adds a perm_hold stall input.  Revision: 1.0
// ----------------------------------------------------------------------------
module perm_step_scheduler #(
  parameter int NUM_STEPS       = 18,
  parameter int ROUNDS_PER_STEP = 6,
  parameter int UNROLL          = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef SCHED_HOLD_EN
  input  logic       perm_hold,
`endif
  output logic       en_round,
  output logic       en_mix,
  output logic       first_cycle,
  output logic [5:0] step_idx,
  output logic [2:0] round_idx,
  output logic       busy,
  output logic       perm_done
);

  localparam logic [5:0] LAST_STEP  = 6'(NUM_STEPS - 1);
  localparam logic [2:0] LAST_ROUND = 3'(ROUNDS_PER_STEP - UNROLL);
  localparam logic [2:0] ROUND_INC  = 3'(UNROLL);

  if (UNROLL < 1 || (ROUNDS_PER_STEP % UNROLL) != 0) begin : g_bad_unroll
    $error("UNROLL must be >= 1 and divide ROUNDS_PER_STEP");
  end
  if (NUM_STEPS < 2 || NUM_STEPS > 63) begin : g_bad_steps
    $error("NUM_STEPS must be in 2..63");
  end
  if (ROUNDS_PER_STEP - UNROLL > 7) begin : g_bad_rounds
    $error("round_idx does not fit in 3 bits");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_MIX   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] step_q, step_d;
  logic [2:0] round_q, round_d;
  logic       hold;

`ifdef SCHED_HOLD_EN
  assign hold = perm_hold;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      round_q <= round_d;
    end
  end

  // A hold in ROUND/MIX leaves every *_d equal to *_q and drops the enables.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    round_d     = round_q;
    en_round    = 1'b0;
    en_mix      = 1'b0;
    first_cycle = 1'b0;
    perm_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ROUND;
          step_d  = '0;
          round_d = '0;
        end
      end
      S_ROUND: begin
        if (!hold) begin
          en_round    = 1'b1;
          first_cycle = (step_q == 6'd0) && (round_q == 3'd0);
          if (round_q == LAST_ROUND) begin
            state_d = S_MIX;
            round_d = '0;
          end else begin
            round_d = round_q + ROUND_INC;
          end
        end
      end
      S_MIX: begin
        if (!hold) begin
          en_mix  = 1'b1;
          round_d = '0;
          if (step_q == LAST_STEP) begin
            state_d = S_DONE;
            step_d  = '0;
          end else begin
            state_d = S_ROUND;
            step_d  = step_q + 6'd1;
          end
        end
      end
      S_DONE: begin
        perm_done = 1'b1;
        state_d   = S_IDLE;
        step_d    = '0;
        round_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign step_idx  = step_q;
  assign round_idx = round_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire
